y86_decode_rf_pipe: RTL and testbench

Parametrised decode stage for the Y86-64 pipeline, merging decode, register file, writeback, and the D→E pipeline register.
- Derives srcA/srcB/destE/destM from icode.
- Reads the register file and applies full-priority forwarding.
- Detects load/use hazards itself.
- Registers results into the E stage with stall/bubble control.
- Sits between the fetch D register and execute. Replaces the ad-hoc combinational decode with a clocked, resettable successor.

---
 rtl/y86_decode_rf_pipe.sv | 153 +++++++++++++++
 tb/tb_y86_decode_rf_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/y86_decode_rf_pipe.sv
// Y86-64 decode stage: source/dest decode, register file with writeback, forwarding,
// load/use detection and the D->E pipeline register with stall/bubble control.
module y86_decode_rf_pipe #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned NREG    = 16,
    parameter int unsigned RA_W    = $clog2(NREG),
    parameter int unsigned RNONE   = NREG - 1,
    parameter int unsigned RSP_IDX = 4,
    parameter int unsigned STAT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [RA_W-1:0]   D_rA,
    input  logic [RA_W-1:0]   D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [STAT_W-1:0] D_status,
    input  logic              D_valid,
    input  logic              E_stall_in,
    input  logic              E_bubble_in,
    input  logic [RA_W-1:0]   e_destE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [RA_W-1:0]   M_destE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [RA_W-1:0]   M_destM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [RA_W-1:0]   W_destE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [RA_W-1:0]   W_destM,
    input  logic [DATA_W-1:0] W_valM,
    output logic              load_use_stall,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [RA_W-1:0]   E_srcA,
    output logic [RA_W-1:0]   E_srcB,
    output logic [RA_W-1:0]   E_destE,
    output logic [RA_W-1:0]   E_destM,
    output logic [STAT_W-1:0] E_status,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [RA_W-1:0] RegNone = RA_W'(RNONE);
    localparam logic [RA_W-1:0] RegRsp  = RA_W'(RSP_IDX);

    logic [DATA_W-1:0] rf_q [NREG];

    logic [RA_W-1:0]   src_a, src_b, dest_e, dest_m;
    logic [DATA_W-1:0] val_a, val_b;
    logic              bubble;

    logic [3:0]        e_icode_q, e_ifun_q;
    logic [DATA_W-1:0] e_val_c_q, e_val_a_q, e_val_b_q;
    logic [RA_W-1:0]   e_src_a_q, e_src_b_q, e_dest_e_q, e_dest_m_q;
    logic [STAT_W-1:0] e_status_q;

    always_comb begin
        src_a  = RegNone;
        src_b  = RegNone;
        dest_e = RegNone;
        dest_m = RegNone;
        if (D_valid) begin
            case (D_icode)
                4'h2: begin src_a = D_rA; dest_e = D_rB; end
                4'h3: dest_e = D_rB;
                4'h4: begin src_a = D_rA; src_b = D_rB; end
                4'h5: begin src_b = D_rB; dest_m = D_rA; end
                4'h6: begin src_a = D_rA; src_b = D_rB; dest_e = D_rB; end
                4'h8: begin src_b = RegRsp; dest_e = RegRsp; end
                4'h9: begin src_a = RegRsp; src_b = RegRsp; dest_e = RegRsp; end
                4'hA: begin src_a = D_rA; src_b = RegRsp; dest_e = RegRsp; end
                4'hB: begin src_a = RegRsp; src_b = RegRsp; dest_e = RegRsp; dest_m = D_rA; end
                default: ;
            endcase
        end
    end

    // Youngest producer wins; load result beats ALU result within M and W.
    function automatic logic [DATA_W-1:0] fwd(input logic [RA_W-1:0] src);
        if (src == RegNone)       return '0;
        else if (src == e_destE)  return e_valE;
        else if (src == M_destM)  return m_valM;
        else if (src == M_destE)  return M_valE;
        else if (src == W_destM)  return W_valM;
        else if (src == W_destE)  return W_valE;
        else                      return rf_q[src];
    endfunction

    always_comb begin
        val_a = fwd(src_a);
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
        val_b = fwd(src_b);
    end

    assign load_use_stall = (e_icode_q == 4'h5 || e_icode_q == 4'hB) && (e_dest_m_q != RegNone)
                            && (e_dest_m_q == src_a || e_dest_m_q == src_b);
    assign bubble = E_bubble_in | load_use_stall | ~D_valid;

    // Port M is written last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            if (W_destE != RegNone) rf_q[W_destE] <= W_valE;
            if (W_destM != RegNone) rf_q[W_destM] <= W_valM;
        end
    end

    assign dbg_data = rf_q[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            e_icode_q  <= 4'h1;
            e_ifun_q   <= 4'h0;
            e_val_c_q  <= '0;
            e_val_a_q  <= '0;
            e_val_b_q  <= '0;
            e_src_a_q  <= RegNone;
            e_src_b_q  <= RegNone;
            e_dest_e_q <= RegNone;
            e_dest_m_q <= RegNone;
            e_status_q <= '0;
        end else if (!E_stall_in) begin
            e_icode_q  <= D_icode;
            e_ifun_q   <= D_ifun;
            e_val_c_q  <= D_valC;
            e_val_a_q  <= val_a;
            e_val_b_q  <= val_b;
            e_src_a_q  <= src_a;
            e_src_b_q  <= src_b;
            e_dest_e_q <= dest_e;
            e_dest_m_q <= dest_m;
            e_status_q <= D_status;
        end
    end

    assign E_icode  = e_icode_q;
    assign E_ifun   = e_ifun_q;
    assign E_valC   = e_val_c_q;
    assign E_valA   = e_val_a_q;
    assign E_valB   = e_val_b_q;
    assign E_srcA   = e_src_a_q;
    assign E_srcB   = e_src_b_q;
    assign E_destE  = e_dest_e_q;
    assign E_destM  = e_dest_m_q;
    assign E_status = e_status_q;

endmodule

// File: tb/tb_y86_decode_rf_pipe.sv
// Directed bench for y86_decode_rf_pipe: reset, forwarding priority, dual writeback,
// load/use, call, stall/bubble and mid-stream reset.
module tb_y86_decode_rf_pipe;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 4;
    localparam logic [AW-1:0] RN = 4'd15;

    logic          clk, rst;
    logic [3:0]    D_icode, D_ifun;
    logic [AW-1:0] D_rA, D_rB;
    logic [DW-1:0] D_valC, D_valP;
    logic [1:0]    D_status;
    logic          D_valid, E_stall_in, E_bubble_in;
    logic [AW-1:0] e_destE, M_destE, M_destM, W_destE, W_destM, dbg_addr;
    logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM, dbg_data;
    logic          load_use_stall;
    logic [3:0]    E_icode, E_ifun;
    logic [DW-1:0] E_valC, E_valA, E_valB;
    logic [AW-1:0] E_srcA, E_srcB, E_destE, E_destM;
    logic [1:0]    E_status;

    int n_checks = 0;
    int n_fail   = 0;

    y86_decode_rf_pipe dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_status(D_status), .D_valid(D_valid),
        .E_stall_in(E_stall_in), .E_bubble_in(E_bubble_in),
        .e_destE(e_destE), .e_valE(e_valE), .M_destE(M_destE), .M_valE(M_valE),
        .M_destM(M_destM), .m_valM(m_valM), .W_destE(W_destE), .W_valE(W_valE),
        .W_destM(W_destM), .W_valM(W_valM),
        .load_use_stall(load_use_stall),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_srcA(E_srcA), .E_srcB(E_srcB), .E_destE(E_destE),
        .E_destM(E_destM), .E_status(E_status),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_check(input string tag, input logic [AW-1:0] idx, input logic [63:0] exp);
        dbg_addr = idx;
        #1;
        check_eq(tag, dbg_data, exp);
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        D_icode = ic; D_ifun = 4'h0; D_rA = ra; D_rB = rb; D_valid = 1'b1;
    endtask

    initial begin
        rst = 0; D_icode = 4'h1; D_ifun = 0; D_rA = RN; D_rB = RN; D_valC = 0; D_valP = 0;
        D_status = 0; D_valid = 0; E_stall_in = 0; E_bubble_in = 0;
        e_destE = RN; M_destE = RN; M_destM = RN; W_destE = RN; W_destM = RN; dbg_addr = 0;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
        tick();

        // Reset clears RF and discards a coincident writeback
        W_destE = 3; W_valE = 42; tick(); W_destE = RN;
        rf_check("rf3_pre", 3, 42);
        rst = 1; W_destE = 3; W_valE = 99; tick(); rst = 0; W_destE = RN;
        rf_check("rf3_rst", 3, 0);
        check_eq("rst_icode", E_icode, 1);
        check_eq("rst_destE", E_destE, RN);
        check_eq("rst_valA", E_valA, 0);

        W_destE = 2; W_valE = 5; tick(); W_destE = RN;
        rf_check("rf2_wr", 2, 5);

        // Forwarding priority on opq rA=2 rB=3
        set_d(4'h6, 2, 3);
        e_destE = 2; e_valE = 7; M_destM = 2; m_valM = 8;
        #1 check_eq("lu_none", load_use_stall, 0);
        tick();
        check_eq("fw_e", E_valA, 7);
        check_eq("op_icode", E_icode, 6);
        check_eq("op_destE", E_destE, 3);
        check_eq("op_valB", E_valB, 0);
        e_destE = RN; tick();
        check_eq("fw_mM", E_valA, 8);
        M_destM = RN; W_destE = 2; W_valE = 9; tick(); W_destE = RN;
        check_eq("fw_wE", E_valA, 9);
        M_destE = 2; M_valE = 11; W_destM = 2; W_valM = 12; tick();
        check_eq("fw_mE_over_wM", E_valA, 11);
        M_destE = RN; W_destE = 2; W_valE = 13; tick();
        check_eq("fw_wM_over_wE", E_valA, 12);
        W_destE = RN; W_destM = RN; e_destE = 3; e_valE = 64'h33; tick();
        check_eq("rf_read_a", E_valA, 12);
        check_eq("fw_e_valB", E_valB, 64'h33);
        e_destE = RN; e_valE = 0;

        // popq-style dual write to one register
        W_destE = 4; W_valE = 64'h100; W_destM = 4; W_valM = 64'h55; tick();
        W_destE = RN; W_destM = RN;
        rf_check("popq_dual", 4, 64'h55);

        // call
        W_destE = 4; W_valE = 64'h200; tick(); W_destE = RN;
        set_d(4'h8, RN, RN); D_valP = 64'h40; tick();
        check_eq("call_valA", E_valA, 64'h40);
        check_eq("call_valB", E_valB, 64'h200);
        check_eq("call_destE", E_destE, 4);
        check_eq("call_srcA", E_srcA, RN);
        check_eq("call_destM", E_destM, RN);

        // irmovq: RNONE source must not match a RNONE forward destination
        set_d(4'h3, RN, 5); D_valC = 64'h1234; D_status = 2; e_valE = 64'hdead; tick();
        check_eq("rnone_valA", E_valA, 0);
        check_eq("irm_valC", E_valC, 64'h1234);
        check_eq("irm_destE", E_destE, 5);
        check_eq("irm_status", E_status, 2);
        e_valE = 0; D_status = 0;

        // Load/use
        set_d(4'h5, 6, 7); D_valC = 64'h10; tick();
        check_eq("ld_icode", E_icode, 5);
        check_eq("ld_destM", E_destM, 6);
        check_eq("ld_srcB", E_srcB, 7);
        set_d(4'h6, 6, 1);
        #1 check_eq("lu_stall", load_use_stall, 1);
        tick();
        check_eq("lu_bubble_icode", E_icode, 1);
        check_eq("lu_bubble_destE", E_destE, RN);
        check_eq("lu_clear", load_use_stall, 0);
        tick();
        check_eq("lu_after_icode", E_icode, 6);
        check_eq("lu_after_srcA", E_srcA, 6);
        check_eq("lu_after_destE", E_destE, 1);

        // Stall holds, bubble overrides stall
        E_stall_in = 1; set_d(4'h3, RN, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_icode", E_icode, 6);
            check_eq("stall_destE", E_destE, 1);
        end
        E_bubble_in = 1; tick();
        check_eq("stall_bubble", E_icode, 1);
        E_stall_in = 0; E_bubble_in = 0; tick();
        check_eq("resume_icode", E_icode, 3);
        check_eq("resume_destE", E_destE, 2);

        D_valid = 0; tick();
        check_eq("invalid_bubble", E_icode, 1);

        // Reset mid-stream
        set_d(4'h6, 2, 3); tick();
        check_eq("pre_rst_valA", E_valA, 12);
        rst = 1; tick(); rst = 0;
        check_eq("mid_rst_icode", E_icode, 1);
        check_eq("mid_rst_valA", E_valA, 0);
        check_eq("mid_rst_srcA", E_srcA, RN);
        rf_check("mid_rst_rf2", 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
